// File: rtl/vga_line_reader_if.sv
// rtl/vga_line_reader_if.sv - packed-buffer, capture handshake and video output bundle
// Ports (slave = reader side):
//   R/G/B_inRegA, R/G/B_inRegB  in  BUF_W  packed buffers, pixel k at [8k+7:8k]
//   full_a, full_b              in  1      writer finished buffer A / B (level)
//   underrun_clr                in  1      clears sticky underrun
//   readVgaSelector             out 1      1 = writer fills A, 0 = writer fills B
//   R_out, G_out, B_out         out 8      pixel colour, 0 outside active video
//   hsync, vsync                out 1      active-low sync
//   video_on                    out 1      visible pixel on R/G/B_out
//   pixel_x, pixel_y            out 10     coordinates of pixel on R/G/B_out
//   underrun                    out 1      sticky underrun flag
interface vga_line_reader_if #(
   parameter int BUF_W = 128
);
   logic [BUF_W-1:0] R_inRegA;
   logic [BUF_W-1:0] G_inRegA;
   logic [BUF_W-1:0] B_inRegA;
   logic [BUF_W-1:0] R_inRegB;
   logic [BUF_W-1:0] G_inRegB;
   logic [BUF_W-1:0] B_inRegB;
   logic             full_a;
   logic             full_b;
   logic             underrun_clr;
   logic             readVgaSelector;
   logic [7:0]       R_out;
   logic [7:0]       G_out;
   logic [7:0]       B_out;
   logic             hsync;
   logic             vsync;
   logic             video_on;
   logic [9:0]       pixel_x;
   logic [9:0]       pixel_y;
   logic             underrun;

   modport slave (
      input  R_inRegA, G_inRegA, B_inRegA, R_inRegB, G_inRegB, B_inRegB,
      input  full_a, full_b, underrun_clr,
      output readVgaSelector, R_out, G_out, B_out, hsync, vsync, video_on,
      output pixel_x, pixel_y, underrun
   );

   modport master (
      output R_inRegA, G_inRegA, B_inRegA, R_inRegB, G_inRegB, B_inRegB,
      output full_a, full_b, underrun_clr,
      input  readVgaSelector, R_out, G_out, B_out, hsync, vsync, video_on,
      input  pixel_x, pixel_y, underrun
   );
endinterface

// File: rtl/vga_line_reader.sv
// rtl/vga_line_reader.sv - VGA raster timing plus ping-pong packed-buffer pixel reader
// Ports:
//   clk    in  1  system clock, posedge
//   reset  in  1  asynchronous active-high reset
//   bus    vga_line_reader_if.slave  buffers, capture handshake, video outputs
module vga_line_reader #(
   parameter int H_ACTIVE    = 640,
   parameter int H_FP        = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BP        = 48,
   parameter int V_ACTIVE    = 480,
   parameter int V_FP        = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BP        = 33,
   parameter int PIX_DIV     = 2,
   parameter int PIX_PER_BUF = 16
) (
   input logic                clk,
   input logic                reset,
   vga_line_reader_if.slave   bus
);
   localparam int BUF_W = PIX_PER_BUF * 8;
   localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
   localparam int REM_W = $clog2(PIX_PER_BUF + 1);

   localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
   localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
   localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

   typedef enum logic {S_EMPTY, S_HOLD} state_t;

   logic [DIV_W-1:0] div_q, div_d;
   logic [9:0]       h_q, h_d;
   logic [9:0]       v_q, v_d;
   state_t           state_q;
   logic [REM_W-1:0] rem_q;
   logic [BUF_W-1:0] sr_r_q, sr_g_q, sr_b_q;
   logic             sel_q;
   logic [7:0]       r_q, g_q, b_q;
   logic             hs_q, vs_q, von_q, und_q;
   logic [9:0]       px_q, py_q;

   logic pix_en;
   logic active;
   logic und_set;

   assign pix_en  = (div_q == DIV_W'(PIX_DIV - 1));
   assign active  = (h_q < H_ACT) && (v_q < V_ACT);
   // A visible slot with nothing held locally; a capture in the same cycle does not rescue it.
   assign und_set = pix_en && active && (rem_q == '0);

   always_comb begin
      div_d = pix_en ? '0 : div_q + DIV_W'(1);
      h_d   = h_q;
      v_d   = v_q;
      if (pix_en) begin
         if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
         end else begin
            h_d = h_q + 10'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q   <= '0;
         h_q     <= '0;
         v_q     <= '0;
         state_q <= S_EMPTY;
         rem_q   <= '0;
         sr_r_q  <= '0;
         sr_g_q  <= '0;
         sr_b_q  <= '0;
         sel_q   <= 1'b1;
         r_q     <= '0;
         g_q     <= '0;
         b_q     <= '0;
         hs_q    <= 1'b1;
         vs_q    <= 1'b1;
         von_q   <= 1'b0;
         px_q    <= '0;
         py_q    <= '0;
         und_q   <= 1'b0;
      end else begin
         div_q <= div_d;
         h_q   <= h_d;
         v_q   <= v_d;

         // Outputs describe the slot the counters pointed at before this advance.
         if (pix_en) begin
            von_q <= active;
            hs_q  <= !((h_q >= HS_START) && (h_q < HS_END));
            vs_q  <= !((v_q >= VS_START) && (v_q < VS_END));
            px_q  <= h_q;
            py_q  <= v_q;
            r_q   <= '0;
            g_q   <= '0;
            b_q   <= '0;
         end

         if (und_set) begin
            und_q <= 1'b1;
         end else if (bus.underrun_clr) begin
            und_q <= 1'b0;
         end

         case (state_q)
            S_EMPTY: begin
               // Only the buffer the writer was told to fill can be taken; the selector
               // then flips so the writer moves to the other one.
               if (sel_q && bus.full_a) begin
                  sr_r_q  <= bus.R_inRegA;
                  sr_g_q  <= bus.G_inRegA;
                  sr_b_q  <= bus.B_inRegA;
                  rem_q   <= REM_W'(PIX_PER_BUF);
                  sel_q   <= 1'b0;
                  state_q <= S_HOLD;
               end else if (!sel_q && bus.full_b) begin
                  sr_r_q  <= bus.R_inRegB;
                  sr_g_q  <= bus.G_inRegB;
                  sr_b_q  <= bus.B_inRegB;
                  rem_q   <= REM_W'(PIX_PER_BUF);
                  sel_q   <= 1'b1;
                  state_q <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (pix_en && active) begin
                  r_q    <= sr_r_q[7:0];
                  g_q    <= sr_g_q[7:0];
                  b_q    <= sr_b_q[7:0];
                  sr_r_q <= sr_r_q >> 8;
                  sr_g_q <= sr_g_q >> 8;
                  sr_b_q <= sr_b_q >> 8;
                  rem_q  <= rem_q - REM_W'(1);
                  if (rem_q == REM_W'(1)) begin
                     state_q <= S_EMPTY;
                  end
               end
            end
            default: state_q <= S_EMPTY;
         endcase
      end
   end

   assign bus.readVgaSelector = sel_q;
   assign bus.R_out           = r_q;
   assign bus.G_out           = g_q;
   assign bus.B_out           = b_q;
   assign bus.hsync           = hs_q;
   assign bus.vsync           = vs_q;
   assign bus.video_on        = von_q;
   assign bus.pixel_x         = px_q;
   assign bus.pixel_y         = py_q;
   assign bus.underrun        = und_q;
endmodule
